// File: rtl/dual_input_debouncer.sv
// Two-channel input conditioner: synchroniser, debounce FSM with hold counter, clean level and edge pulses.
// Optional aborted-transition counter on port glitch_cnt, enabled by defining DEBOUNCE_GLITCH_CNT_EN.

module dual_input_debouncer_chan #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic clean_o,
    output logic rise_o,
    output logic fall_o,
    output logic abort_o
);
    localparam logic [1:0] ST_STABLE_LO = 2'd0;
    localparam logic [1:0] ST_WAIT_HI   = 2'd1;
    localparam logic [1:0] ST_STABLE_HI = 2'd2;
    localparam logic [1:0] ST_WAIT_LO   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   x_sync;

    assign x_sync = sync_q[SYNC_STAGES-1];
    assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        abort_o = 1'b0;
        case (state_q)
            ST_STABLE_LO: begin
                if (x_sync) begin
                    // A single-cycle hold requirement commits without visiting WAIT_HI.
                    if (STABLE_CYCLES == 1) begin
                        state_d = ST_STABLE_HI;
                        clean_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_WAIT_HI: begin
                if (!x_sync) begin
                    state_d = ST_STABLE_LO;
                    cnt_d   = '0;
                    abort_o = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_STABLE_HI;
                    cnt_d   = '0;
                    clean_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STABLE_HI: begin
                if (!x_sync) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = ST_STABLE_LO;
                        clean_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            default: begin
                if (x_sync) begin
                    state_d = ST_STABLE_HI;
                    cnt_d   = '0;
                    abort_o = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_STABLE_LO;
                    cnt_d   = '0;
                    clean_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= ST_STABLE_LO;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean_o = clean_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
endmodule

module dual_input_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_raw,
    input  logic       b_raw,
    output logic       a_clean,
    output logic       b_clean,
    output logic       a_rise,
    output logic       a_fall,
    output logic       b_rise,
    output logic       b_fall
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);
    logic a_abort;
    logic b_abort;

    dual_input_debouncer_chan #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_chan_a (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (a_raw),
        .clean_o(a_clean),
        .rise_o (a_rise),
        .fall_o (a_fall),
        .abort_o(a_abort)
    );

    dual_input_debouncer_chan #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_chan_b (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (b_raw),
        .clean_o(b_clean),
        .rise_o (b_rise),
        .fall_o (b_fall),
        .abort_o(b_abort)
    );

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_q, glitch_d;
    logic [8:0] glitch_sum;

    // Nine-bit sum so a double abort near the top still saturates cleanly.
    always_comb begin
        glitch_sum = {1'b0, glitch_q} + {8'd0, a_abort} + {8'd0, b_abort};
        glitch_d   = glitch_sum[8] ? 8'hFF : glitch_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_cnt = glitch_q;
`else
    logic unused_abort;
    assign unused_abort = a_abort ^ b_abort;
`endif
endmodule

// File: tb/tb_dual_input_debouncer.sv
// Self-checking bench for dual_input_debouncer: directed vector table, corner sequences, random vs. model.
// Glitch-counter checks are active when DEBOUNCE_GLITCH_CNT_EN is defined.

module tb_dual_input_debouncer;
    localparam int SYNC   = 2;
    localparam int STABLE = 4;

    logic clk = 1'b0;
    logic rst, a_raw, b_raw;
    logic a_clean, b_clean, a_rise, a_fall, b_rise, b_fall;
    logic [5:0] dut_out;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    always #5 clk = ~clk;

    dual_input_debouncer #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE),
        .CNT_W        (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .a_raw  (a_raw),
        .b_raw  (b_raw),
        .a_clean(a_clean),
        .b_clean(b_clean),
        .a_rise (a_rise),
        .a_fall (a_fall),
        .b_rise (b_rise),
        .b_fall (b_fall)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt(glitch_cnt)
`endif
    );

    // {a_clean, b_clean, a_rise, a_fall, b_rise, b_fall}
    assign dut_out = {a_clean, b_clean, a_rise, a_fall, b_rise, b_fall};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a change is accepted once the synchronised input has
    // disagreed with the clean level for STABLE consecutive samples.
    bit qa[$];
    bit qb[$];
    bit m_clean[2];
    bit m_rise[2];
    bit m_fall[2];
    int m_run[2];
    int m_gl;

    function automatic void model_step(input bit r, input bit a, input bit b);
        bit x[2];
        int aborts;
        if (r) begin
            qa = {};
            qb = {};
            for (int i = 0; i < SYNC; i++) begin
                qa.push_back(1'b0);
                qb.push_back(1'b0);
            end
            for (int c = 0; c < 2; c++) begin
                m_clean[c] = 0; m_rise[c] = 0; m_fall[c] = 0; m_run[c] = 0;
            end
            m_gl = 0;
            return;
        end
        x[0] = qa.pop_front(); qa.push_back(a);
        x[1] = qb.pop_front(); qb.push_back(b);
        aborts = 0;
        for (int c = 0; c < 2; c++) begin
            m_rise[c] = 0;
            m_fall[c] = 0;
            if (x[c] != m_clean[c]) begin
                m_run[c]++;
                if (m_run[c] == STABLE) begin
                    m_clean[c] = x[c];
                    m_run[c]   = 0;
                    if (x[c]) m_rise[c] = 1; else m_fall[c] = 1;
                end
            end else begin
                if (m_run[c] > 0) aborts++;
                m_run[c] = 0;
            end
        end
        m_gl = (m_gl + aborts > 255) ? 255 : m_gl + aborts;
    endfunction

    function automatic logic [5:0] model_out();
        return {m_clean[0], m_clean[1], m_rise[0], m_fall[0], m_rise[1], m_fall[1]};
    endfunction

    // Drive at negedge, let one rising edge pass, sample at the following negedge.
    task automatic cycle(input bit r, input bit a, input bit b);
        rst = r; a_raw = a; b_raw = b;
        @(posedge clk);
        model_step(r, a, b);
        @(negedge clk);
    endtask

    typedef struct {
        bit       rst;
        bit       a;
        bit       b;
        bit [5:0] exp;
        bit [7:0] gl;
    } vec_t;

    vec_t tbl[$];

    task automatic put(input bit r, input bit a, input bit b, input bit [5:0] exp, input bit [7:0] gl);
        vec_t v;
        v.rst = r; v.a = a; v.b = b; v.exp = exp; v.gl = gl;
        tbl.push_back(v);
    endtask

    initial begin
        logic [5:0] acc;
        int rise_row, fall_row, rise_cnt;
        int ra_left, rb_left;
        bit ra, rb, rr;

        rst = 1'b1; a_raw = 1'b0; b_raw = 1'b0;

        // Reset with raw inputs high, then single-channel rise/fall, a 3-cycle glitch, dual rise/fall.
        repeat (3) put(1, 1, 1, 6'b000000, 0);
        repeat (5) put(0, 1, 0, 6'b000000, 0);
        put(0, 1, 0, 6'b101000, 0);
        repeat (3) put(0, 1, 0, 6'b100000, 0);
        repeat (5) put(0, 0, 0, 6'b100000, 0);
        put(0, 0, 0, 6'b000100, 0);
        repeat (3) put(0, 0, 0, 6'b000000, 0);
        repeat (3) put(0, 1, 0, 6'b000000, 0);
        repeat (2) put(0, 0, 0, 6'b000000, 0);
        repeat (6) put(0, 0, 0, 6'b000000, 1);
        repeat (5) put(0, 1, 1, 6'b000000, 1);
        put(0, 1, 1, 6'b111010, 1);
        repeat (4) put(0, 1, 1, 6'b110000, 1);
        repeat (5) put(0, 0, 0, 6'b110000, 1);
        put(0, 0, 0, 6'b000101, 1);
        repeat (3) put(0, 0, 0, 6'b000000, 1);

        @(negedge clk);
        foreach (tbl[i]) begin
            cycle(tbl[i].rst, tbl[i].a, tbl[i].b);
            check($sformatf("vec%0d_outputs", i), {2'b00, dut_out}, {2'b00, tbl[i].exp});
`ifdef DEBOUNCE_GLITCH_CNT_EN
            check($sformatf("vec%0d_glitch", i), glitch_cnt, tbl[i].gl);
`endif
        end

        // Reset asserted while channel A sits in WAIT_LO.
        repeat (8) cycle(0, 1, 0);
        check("rstwait_clean_before", {7'd0, a_clean}, 8'd1);
        repeat (4) cycle(0, 0, 0);
        check("rstwait_still_high", {7'd0, a_clean}, 8'd1);
        cycle(1, 0, 0);
        check("rstwait_after_rst", {2'b00, dut_out}, 8'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("rstwait_glitch_clr", glitch_cnt, 8'd0);
`endif
        acc = '0;
        repeat (8) begin
            cycle(0, 0, 0);
            acc |= dut_out;
        end
        check("rstwait_quiet", {2'b00, acc}, 8'd0);

        // Exactly STABLE high samples is enough to commit.
        rise_row = 0; fall_row = 0; rise_cnt = 0;
        for (int r = 1; r <= 14; r++) begin
            cycle(0, (r <= 4), 0);
            if (a_rise) begin rise_cnt++; if (rise_row == 0) rise_row = r; end
            if (a_fall && fall_row == 0) fall_row = r;
        end
        check("min_hold_rise_row", 8'(rise_row), 8'd6);
        check("min_hold_fall_row", 8'(fall_row), 8'd10);
        check("min_hold_rise_cnt", 8'(rise_cnt), 8'd1);

        // Fast toggling never reaches the hold requirement.
        acc = '0;
        for (int r = 0; r < 40; r++) begin
            cycle(0, (r % 2 == 0), (r % 3 == 0));
            acc |= dut_out;
        end
        repeat (6) cycle(0, 0, 0);
        acc |= dut_out;
        check("fast_toggle_quiet", {2'b00, acc}, 8'd0);

        // Repeated aborts on both channels (two per pattern).
        cycle(1, 0, 0);
        acc = '0;
        for (int k = 0; k < 300; k++) begin
            cycle(0, 1, 1); cycle(0, 1, 1);
            cycle(0, 0, 0); cycle(0, 0, 0);
            acc |= dut_out;
`ifdef DEBOUNCE_GLITCH_CNT_EN
            if (k == 40) check("glitch_mid", glitch_cnt, 8'(m_gl));
`endif
        end
        check("abort_storm_quiet", {2'b00, acc}, 8'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("glitch_saturated", glitch_cnt, 8'hFF);
`endif

        // Random run-length stimulus against the model.
        ra = 0; rb = 0; ra_left = 0; rb_left = 0;
        for (int n = 0; n < 3000; n++) begin
            if (ra_left == 0) begin ra = ~ra; ra_left = $urandom_range(1, 8); end
            if (rb_left == 0) begin rb = ~rb; rb_left = $urandom_range(1, 8); end
            ra_left--; rb_left--;
            rr = ($urandom_range(0, 299) == 0);
            cycle(rr, ra, rb);
            check("random_outputs", {2'b00, dut_out}, {2'b00, model_out()});
`ifdef DEBOUNCE_GLITCH_CNT_EN
            check("random_glitch", glitch_cnt, 8'(m_gl));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
